// File: rtl/gray2bin_pipe.sv
// Elastic, PIPE-stage Gray-to-binary decoder with valid/ready on both sides.
// Optional single-bit step checker is compiled in with `define GRAY2BIN_STEP_CHECK_EN.
module gray2bin_pipe #(
    parameter int DW   = 8,
    parameter int PIPE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] gray,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] bin,
    output logic          step_err,
    output logic          err_seen
);

    localparam int SEG = (DW + PIPE - 1) / PIPE;

    // Decode only the bits of segment s; bits above it are already binary,
    // so r[i+1] at the segment's top edge is the carry from earlier stages.
    function automatic logic [DW-1:0] decode_seg(input logic [DW-1:0] w, input int s);
        logic [DW-1:0] r;
        int            hi;
        int            lo;
        r  = w;
        hi = DW - 1 - s * SEG;
        lo = DW - (s + 1) * SEG;
        for (int i = DW - 2; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = r[i+1] ^ r[i];
            end
        end
        return r;
    endfunction

    logic [DW-1:0]   data_p [PIPE];
    logic [PIPE-1:0] vld_p;
    logic [PIPE-1:0] ld;
    logic            in_xfer;

    // A stage may load when the output is being taken or any stage from it
    // down to the last is empty.
    always_comb begin
        logic tail_full;
        ld        = '0;
        tail_full = 1'b1;
        for (int s = PIPE - 1; s >= 0; s--) begin
            tail_full = tail_full & vld_p[s];
            ld[s]     = out_ready || !tail_full;
        end
    end

    assign in_ready = rst_n && ld[0];
    assign in_xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            if (ld[0]) begin
                vld_p[0] <= in_valid;
            end
            for (int s = 1; s < PIPE; s++) begin
                if (ld[s]) begin
                    vld_p[s] <= vld_p[s-1];
                end
            end
        end
    end

    // Data registers carry no reset; the output is masked by the valid bit.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            data_p[0] <= decode_seg(gray, 0);
        end
        for (int s = 1; s < PIPE; s++) begin
            if (ld[s] && vld_p[s-1]) begin
                data_p[s] <= decode_seg(data_p[s-1], s);
            end
        end
    end

    assign out_valid = vld_p[PIPE-1];
    assign bin       = out_valid ? data_p[PIPE-1] : '0;

`ifdef GRAY2BIN_STEP_CHECK_EN
    function automatic int popcount(input logic [DW-1:0] x);
        int cnt;
        cnt = 0;
        for (int i = 0; i < DW; i++) begin
            cnt = cnt + int'(x[i]);
        end
        return cnt;
    endfunction

    logic [DW-1:0]   prev_gray;
    logic            have_prev;
    logic [PIPE-1:0] err_p;
    logic            seen_q;
    logic            step_bad;
    logic            out_xfer;

    assign step_bad = have_prev && (popcount(gray ^ prev_gray) > 1);
    assign out_xfer = vld_p[PIPE-1] && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
            err_p     <= '0;
            seen_q    <= 1'b0;
        end else begin
            if (in_xfer) begin
                prev_gray <= gray;
                have_prev <= 1'b1;
            end
            if (ld[0]) begin
                err_p[0] <= step_bad;
            end
            for (int s = 1; s < PIPE; s++) begin
                if (ld[s]) begin
                    err_p[s] <= err_p[s-1];
                end
            end
            if (out_xfer && err_p[PIPE-1]) begin
                seen_q <= 1'b1;
            end
        end
    end

    assign step_err = vld_p[PIPE-1] && err_p[PIPE-1];
    assign err_seen = seen_q;
`else
    assign step_err = 1'b0;
    assign err_seen = 1'b0;
`endif

endmodule
